// File: rtl/rijndael_iter_core.sv
// Iterative Rijndael encryption core (NB/NK = 4, 6 or 8 columns/words) with one round datapath
// per cycle; define RIJNDAEL_ITER_TWOROUND_EN to cascade two rounds per cycle.
module rijndael_iter_core #(
    parameter int NB = 4,
    parameter int NK = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [32*NB-1:0]          in_state_i,
    output logic [3:0]                rk_idx_o,
`ifdef RIJNDAEL_ITER_TWOROUND_EN
    input  logic [2*32*NB-1:0]        roundkey_i,
`else
    input  logic [32*NB-1:0]          roundkey_i,
`endif
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [32*NB-1:0]          out_state_o,
    output logic                      busy_o
);
    localparam int STATESIZE = 32 * NB;
    localparam int NR = ((NB > NK) ? NB : NK) + 6;
`ifdef RIJNDAEL_ITER_TWOROUND_EN
    localparam int RPC = 2;
`else
    localparam int RPC = 1;
`endif
    localparam logic [3:0] NR_L     = 4'(NR);
    localparam logic [3:0] RPC_L    = 4'(RPC);
    localparam logic [3:0] LAST_RND = 4'(NR - RPC + 1);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("rijndael_iter_core: NB=%0d is not 4, 6 or 8", NB);
    end
    if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
        $error("rijndael_iter_core: NK=%0d is not 4, 6 or 8", NK);
    end

    // Byte x of the table sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    fsm_e                 fsm_q, fsm_d;
    logic [STATESIZE-1:0] state_q, state_d;
    logic [3:0]           rnd_q, rnd_d;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Wide blocks (NB=8) use the larger row offsets 1, 3, 4.
    function automatic int shift_of(input int r);
        if (r == 0) return 0;
        if (r == 1) return 1;
        if (r == 2) return (NB == 8) ? 3 : 2;
        return (NB == 8) ? 4 : 3;
    endfunction

    function automatic logic [STATESIZE-1:0] round_fn(
        input logic [STATESIZE-1:0] s,
        input logic [STATESIZE-1:0] k,
        input logic                 last
    );
        logic [STATESIZE-1:0] t;
        logic [STATESIZE-1:0] m;
        logic [7:0]           a0, a1, a2, a3;
        int                   src;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = 4 * ((c + shift_of(r)) % NB) + r;
                t[STATESIZE-1-8*(4*c+r) -: 8] = sbox(s[STATESIZE-1-8*src -: 8]);
            end
        end
        m = t;
        if (!last) begin
            for (int c = 0; c < NB; c++) begin
                a0 = t[STATESIZE-1-32*c  -: 8];
                a1 = t[STATESIZE-9-32*c  -: 8];
                a2 = t[STATESIZE-17-32*c -: 8];
                a3 = t[STATESIZE-25-32*c -: 8];
                m[STATESIZE-1-32*c  -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                m[STATESIZE-9-32*c  -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                m[STATESIZE-17-32*c -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                m[STATESIZE-25-32*c -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        return m ^ k;
    endfunction

    // Cascade of RPC round datapaths; only the final stage may be the MixColumns-free last round.
    logic [STATESIZE-1:0] stage [RPC+1];
    assign stage[0] = state_q;

    for (genvar gi = 0; gi < RPC; gi++) begin : g_round
        logic is_last;
        if (gi == RPC - 1) begin : g_tail
            assign is_last = (rnd_q + 4'(gi)) == NR_L;
        end else begin : g_head
            assign is_last = 1'b0;
        end
        assign stage[gi+1] = round_fn(stage[gi], roundkey_i[gi*STATESIZE +: STATESIZE], is_last);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rnd_d   = rnd_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid_i) begin
                    state_d = in_state_i ^ roundkey_i[STATESIZE-1:0];
                    rnd_d   = 4'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                state_d = stage[RPC];
                rnd_d   = rnd_q + RPC_L;
                if (rnd_q == LAST_RND) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready_o  = (fsm_q == IDLE);
    assign out_valid_o = (fsm_q == DONE);
    assign busy_o      = (fsm_q == RUN) || (fsm_q == DONE);
    assign rk_idx_o    = (fsm_q == RUN) ? rnd_q : 4'd0;
    assign out_state_o = out_valid_o ? state_q : '0;

endmodule

// File: tb/tb_rijndael_iter_core.sv
// Bench for rijndael_iter_core: nine NB/NK configurations, each fed by its own round-key store,
// checked against FIPS-197 vectors and a byte-level Rijndael reference through a scoreboard.
module tb_rijndael_iter_core;
    localparam int NCFG = 9;
`ifdef RIJNDAEL_ITER_TWOROUND_EN
    localparam int RPC = 2;
`else
    localparam int RPC = 1;
`endif
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] PT     = 256'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] CT128  = 256'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] CT256  = 256'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [NCFG];
    logic         out_ready [NCFG];
    logic         in_ready  [NCFG];
    logic         out_valid [NCFG];
    logic         busy      [NCFG];
    logic [3:0]   rk_idx    [NCFG];
    logic [255:0] in_state  [NCFG];
    logic [255:0] out_state [NCFG];
    logic [255:0] rks       [NCFG][16];
    logic [7:0]   sbm       [256];
    logic [255:0] exp_q [$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           n_out = 0;

    always #5 clk = ~clk;

    function automatic int cfg_nb(input int i); return 4 + 2 * (i / 3); endfunction
    function automatic int cfg_nk(input int i); return 4 + 2 * (i % 3); endfunction
    function automatic int cfg_nr(input int i);
        return ((cfg_nb(i) > cfg_nk(i)) ? cfg_nb(i) : cfg_nk(i)) + 6;
    endfunction

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
        localparam int GNB = 4 + 2 * (gi / 3);
        localparam int GNK = 4 + 2 * (gi % 3);
        localparam int GST = 32 * GNB;
        logic [RPC*GST-1:0] rk_w;
        logic [GST-1:0]     os_w;
        always_comb begin
            rk_w = '0;
            rk_w[GST-1:0] = rks[gi][rk_idx[gi]][GST-1:0];
`ifdef RIJNDAEL_ITER_TWOROUND_EN
            rk_w[2*GST-1:GST] = rks[gi][rk_idx[gi] + 4'd1][GST-1:0];
`endif
        end
        rijndael_iter_core #(.NB(GNB), .NK(GNK)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .in_valid_i  (in_valid[gi]),
            .in_ready_o  (in_ready[gi]),
            .in_state_i  (in_state[gi][GST-1:0]),
            .rk_idx_o    (rk_idx[gi]),
            .roundkey_i  (rk_w),
            .out_valid_o (out_valid[gi]),
            .out_ready_i (out_ready[gi]),
            .out_state_o (os_w),
            .busy_o      (busy[gi])
        );
        assign out_state[gi] = 256'(os_w);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbm[v] = b;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbm[x[31:24]], sbm[x[23:16]], sbm[x[15:8]], sbm[x[7:0]]};
    endfunction

    task automatic expand_key(input int i);
        int nb, nk, nr;
        logic [255:0] key;
        logic [31:0]  w [120];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        nb = cfg_nb(i); nk = cfg_nk(i); nr = cfg_nr(i);
        key = KEY256 >> (256 - 32 * nk);
        rc = 8'h01;
        for (int j = 0; j < nk; j++) w[j] = key[32*(nk-1-j) +: 32];
        for (int j = nk; j < nb * (nr + 1); j++) begin
            tmp = w[j-1];
            if (j % nk == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && j % nk == 4) begin
                tmp = sub_word(tmp);
            end
            w[j] = w[j-nk] ^ tmp;
        end
        for (int r = 0; r < 16; r++) begin
            rks[i][r] = '0;
            if (r <= nr)
                for (int j = 0; j < nb; j++) rks[i][r][32*(nb-1-j) +: 32] = w[r*nb+j];
        end
    endtask

    function automatic logic [255:0] model_encrypt(input int i, input logic [255:0] pt);
        int nb, nr, src;
        int sh [4];
        logic [7:0] s [32];
        logic [7:0] t [32];
        logic [7:0] a0, a1, a2, a3;
        logic [255:0] res;
        nb = cfg_nb(i); nr = cfg_nr(i);
        sh[0] = 0; sh[1] = 1; sh[2] = (nb == 8) ? 3 : 2; sh[3] = (nb == 8) ? 4 : 3;
        for (int b = 0; b < 4 * nb; b++)
            s[b] = pt[8*(4*nb-1-b) +: 8] ^ rks[i][0][8*(4*nb-1-b) +: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int c = 0; c < nb; c++)
                for (int row = 0; row < 4; row++) begin
                    src = 4 * ((c + sh[row]) % nb) + row;
                    t[4*c+row] = sbm[s[src]];
                end
            for (int c = 0; c < nb; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < nr) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int b = 0; b < 4 * nb; b++) s[b] = s[b] ^ rks[i][r][8*(4*nb-1-b) +: 8];
        end
        res = '0;
        for (int b = 0; b < 4 * nb; b++) res[8*(4*nb-1-b) +: 8] = s[b];
        return res;
    endfunction

    function automatic logic [255:0] rand_block();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- scoreboard consumer ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NCFG; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    check("out_expected", 256'(exp_q.size() != 0), 256'd1);
                    if (exp_q.size() != 0) begin
                        check($sformatf("ct_cfg%0d", i), out_state[i], exp_q.pop_front());
                        n_out++;
                    end
                    $display("out cfg=%0d nb=%0d nk=%0d ct=%h", i, cfg_nb(i), cfg_nk(i),
                             out_state[i]);
                end
            end
        end
    end

    // ---------------- stimulus tasks ----------------
    task automatic send(input int i, input logic [255:0] pt);
        int n;
        n = 0;
        in_valid[i] = 1'b1;
        in_state[i] = pt;
        @(negedge clk);
        while (!in_ready[i] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 256'(in_ready[i]), 256'd1);
        if (in_ready[i]) exp_q.push_back(model_encrypt(i, pt));
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        in_state[i] = rand_block();
    endtask

    task automatic run_vec(input int i, input logic [255:0] ct, input string tag);
        int cyc;
        cyc = 0;
        out_ready[i] = 1'b1;
        check({tag, "_idx_idle"}, 256'(rk_idx[i]), 256'd0);
        send(i, PT);
        while (!out_valid[i] && cyc < 40) begin
            check({tag, "_rk_idx"}, 256'(rk_idx[i]), 256'(1 + cyc * RPC));
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 256'(cyc), 256'(cfg_nr(i) / RPC));
        check({tag, "_ct"}, out_state[i], ct);
        @(posedge clk); #1;
        check({tag, "_back_idle"}, 256'(in_ready[i]), 256'd1);
    endtask

    task automatic backpressure(input int i);
        logic [255:0] held;
        int cyc;
        cyc = 0;
        out_ready[i] = 1'b0;
        send(i, rand_block());
        while (!out_valid[i] && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_valid", 256'(out_valid[i]), 256'd1);
        held = out_state[i];
        in_valid[i] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_state[i] = rand_block();
            @(negedge clk);
            check("bp_hold", out_state[i], held);
            check("bp_in_ready", 256'(in_ready[i]), 256'd0);
            check("bp_valid_hold", 256'(out_valid[i]), 256'd1);
            @(posedge clk); #1;
        end
        in_valid[i] = 1'b0;
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        check("bp_no_accept", 256'(busy[i]), 256'd0);
        check("bp_idle", 256'(in_ready[i]), 256'd1);
    endtask

    task automatic reset_mid(input int i);
        out_ready[i] = 1'b1;
        send(i, rand_block());
        repeat ((5 - 1) / RPC) begin
            @(posedge clk); #1;
        end
        check("rm_idx5", 256'(rk_idx[i]), 256'd5);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("rm_in_ready", 256'(in_ready[i]), 256'd1);
        check("rm_out_valid", 256'(out_valid[i]), 256'd0);
        check("rm_busy", 256'(busy[i]), 256'd0);
        check("rm_out_state", out_state[i], 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_vec(i, CT128, "rm_after");
    endtask

    task automatic stream(input int i);
        int target, guard;
        target = n_out + 20;
        guard = 0;
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send(i, rand_block());
                end
            end
            begin
                while (n_out < target && guard < 3000) begin
                    out_ready[i] = ($urandom_range(0, 2) != 0);
                    @(posedge clk); #1;
                    guard++;
                end
            end
        join
        out_ready[i] = 1'b1;
        check($sformatf("stream_cnt_cfg%0d", i), 256'(n_out), 256'(target));
        check($sformatf("stream_q_cfg%0d", i), 256'(exp_q.size()), 256'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < NCFG; i++) begin
            in_valid[i] = 1'b0;
            out_ready[i] = 1'b1;
            in_state[i] = '0;
        end
        build_sbox();
        for (int i = 0; i < NCFG; i++) expand_key(i);
        #12;
        for (int i = 0; i < NCFG; i += 8) begin
            check("rst_in_ready", 256'(in_ready[i]), 256'd1);
            check("rst_out_valid", 256'(out_valid[i]), 256'd0);
            check("rst_busy", 256'(busy[i]), 256'd0);
            check("rst_rk_idx", 256'(rk_idx[i]), 256'd0);
            check("rst_out_state", out_state[i], 256'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_vec(0, CT128, "aes128");
        run_vec(2, CT256, "aes256");
        backpressure(0);
        reset_mid(0);
        for (int i = 0; i < NCFG; i++) stream(i);
        repeat (3) @(posedge clk);
        check("final_q_empty", 256'(exp_q.size()), 256'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
